// File: rtl/audio_pkg.sv
// Shared audio definitions for the mixer and DAC path; LRCK polarity follows I2S_LJ_EN.
package audio_pkg;

  localparam int AUDIO_W       = 16;
  localparam int SLOT_BITS_DEF = 32;

`ifdef I2S_LJ_EN
  localparam logic LRCK_LEFT = 1'b1;
`else
  localparam logic LRCK_LEFT = 1'b0;
`endif

  typedef logic signed [AUDIO_W-1:0] sample_t;

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: bck toggles every CLK_DIV clk cycles; rise/fall pulse in the cycle before the toggle lands.
// Latency: bck is registered; free-running, no backpressure.
module i2s_bck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic bck,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == CW'(CLK_DIV - 1));
  assign rise = wrap & ~bck;
  assign fall = wrap & bck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) bck <= ~bck;
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// Stereo sample serialiser to I2S pins (left-justified when I2S_LJ_EN is defined); captures one L/R pair per frame.
// Latency: MSB one BCK after capture (I2S) or in the capture cycle (LJ); no backpressure, sample_req marks consumption.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int DATA_W    = AUDIO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] audio_l,
  input  logic [DATA_W-1:0] audio_r,
  input  logic              mute,
  output logic              sample_req,
  output logic              i2s_bck,
  output logic              i2s_lrck,
  output logic              i2s_data
);

  localparam int             FRAME_BITS = 2 * SLOT_BITS;
  localparam int             PAD_W      = SLOT_BITS - DATA_W;
  localparam int             BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0]  LAST_BIT   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0]  LEFT_LAST  = BW'(SLOT_BITS - 1);

  logic                  bck_rise;
  logic                  bck_fall;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] frame_d;
  logic [DATA_W-1:0]     cap_l;
  logic [DATA_W-1:0]     cap_r;
  logic                  frame_start;
  logic                  right_start;

  i2s_bck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bck_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .bck   (i2s_bck),
    .rise  (bck_rise),
    .fall  (bck_fall)
  );

  assign frame_start = bck_fall && (bit_cnt == LAST_BIT);
  assign right_start = bck_fall && (bit_cnt == LEFT_LAST);
  assign cap_l       = mute ? '0 : audio_l;
  assign cap_r       = mute ? '0 : audio_r;
  assign frame_d     = {cap_l, {PAD_W{1'b0}}, cap_r, {PAD_W{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= LAST_BIT;
      shift_q    <= '0;
      i2s_lrck   <= ~LRCK_LEFT;
      i2s_data   <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= frame_start;
      if (bck_fall) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        if (frame_start) begin
          i2s_lrck <= LRCK_LEFT;
`ifdef I2S_LJ_EN
          i2s_data <= frame_d[FRAME_BITS-1];
          shift_q  <= frame_d << 1;
`else
          // Old frame is fully shifted out, so this drives its final R pad bit (0).
          i2s_data <= shift_q[FRAME_BITS-1];
          shift_q  <= frame_d;
`endif
        end else begin
          if (right_start) i2s_lrck <= ~LRCK_LEFT;
          i2s_data <= shift_q[FRAME_BITS-1];
          shift_q  <= shift_q << 1;
        end
      end
    end
  end

  a_edge_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(bck_rise && bck_fall));

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: captures push expected slot words, a BCK-rise monitor decodes and compares.
module tb_i2s_dac_tx;

`ifdef I2S_LJ_EN
  localparam logic LR_LEFT = 1'b1;
  localparam logic LR_RST  = 1'b0;
  localparam int   OFF     = 0;
`else
  localparam logic LR_LEFT = 1'b0;
  localparam logic LR_RST  = 1'b1;
  localparam int   OFF     = 1;
`endif

  typedef struct {
    logic        left;
    logic [15:0] w;
  } slot_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        mute;
  logic        sample_req;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_data;

  int    n_chk  = 0;
  int    n_fail = 0;
  slot_t exp_q[$];

  i2s_dac_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .mute       (mute),
    .sample_req (sample_req),
    .i2s_bck    (i2s_bck),
    .i2s_lrck   (i2s_lrck),
    .i2s_data   (i2s_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for the next sample_req, checks the gap in clk edges, then queues the slot words it should send.
  task automatic cap(input int exp_n, input logic [15:0] el, input logic [15:0] er);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (sample_req) seen = 1'b1;
    end
    check("req_seen", 32'(seen), 32'd1);
    check("req_gap", 32'(n), 32'(exp_n));
    check("cap_lrck", 32'(i2s_lrck), 32'(LR_LEFT));
`ifdef I2S_LJ_EN
    check("cap_data", 32'(i2s_data), 32'(el[15]));
`else
    check("cap_data", 32'(i2s_data), 32'd0);
`endif
    exp_q.push_back('{left: 1'b1, w: el});
    exp_q.push_back('{left: 1'b0, w: er});
  endtask

  task automatic check_reset_outputs();
    check("rst_bck", 32'(i2s_bck), 32'd0);
    check("rst_lrck", 32'(i2s_lrck), 32'(LR_RST));
    check("rst_data", 32'(i2s_data), 32'd0);
    check("rst_req", 32'(sample_req), 32'd0);
  endtask

  // Slot decoder: samples pins on every BCK rise, as the DAC would.
  initial begin
    logic        prev_bck;
    logic        prev_lr;
    logic        armed;
    logic        left;
    logic [15:0] word;
    int          pos;
    int          pad_err;
    slot_t       e;
    prev_bck = 1'b0;
    prev_lr  = LR_RST;
    armed    = 1'b0;
    left     = 1'b0;
    word     = '0;
    pos      = 0;
    pad_err  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        armed   = 1'b0;
        prev_lr = LR_RST;
        exp_q.delete();
      end else if (i2s_bck && !prev_bck) begin
        if (i2s_lrck != prev_lr) begin
          if (armed) check("slot_len", 32'(pos), 32'd32);
          armed   = 1'b1;
          pos     = 0;
          word    = '0;
          pad_err = 0;
          left    = (i2s_lrck == LR_LEFT);
        end
        if (armed) begin
          if (pos >= OFF && pos < OFF + 16) word = {word[14:0], i2s_data};
          else if (i2s_data) pad_err++;
          pos++;
          if (pos == 32) begin
            check("slot_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("slot_side", 32'(left), 32'(e.left));
              check("slot_word", 32'(word), 32'(e.w));
              check("slot_pad", 32'(pad_err), 32'd0);
            end
          end
        end
        prev_lr = i2s_lrck;
      end
      prev_bck = i2s_bck;
    end
  end

  // Waveform shape: BCK half-period 4 clk, LRCK half-period 256 clk, sample_req one cycle wide.
  initial begin
    logic first;
    logic pb;
    logic pl;
    logic preq;
    logic arm_b;
    logic arm_l;
    int   run_b;
    int   run_l;
    first = 1'b1;
    pb    = 1'b0;
    pl    = 1'b0;
    preq  = 1'b0;
    arm_b = 1'b0;
    arm_l = 1'b0;
    run_b = 0;
    run_l = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        first = 1'b1;
        arm_b = 1'b0;
        arm_l = 1'b0;
      end else begin
        if (!first) begin
          if (i2s_bck != pb) begin
            if (arm_b) check("bck_half", 32'(run_b), 32'd4);
            arm_b = 1'b1;
            run_b = 1;
          end else run_b++;
          if (i2s_lrck != pl) begin
            if (arm_l) check("lrck_half", 32'(run_l), 32'd256);
            arm_l = 1'b1;
            run_l = 1;
          end else run_l++;
          if (preq) check("req_width", 32'(sample_req), 32'd0);
        end
        first = 1'b0;
      end
      pb   = i2s_bck;
      pl   = i2s_lrck;
      preq = sample_req;
    end
  end

  initial begin
    rst_n   = 1'b0;
    mute    = 1'b0;
    audio_l = 16'h8001;
    audio_r = 16'h7FFE;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cap(8, 16'h8001, 16'h7FFE);

    audio_l = 16'h0F0F; audio_r = 16'hF0F0;
    cap(512, 16'h0F0F, 16'hF0F0);
    audio_l = 16'h7FFF; audio_r = 16'h8000;
    cap(512, 16'h7FFF, 16'h8000);
    audio_l = 16'h0001; audio_r = 16'hFFFF;
    cap(512, 16'h0001, 16'hFFFF);

    mute = 1'b1; audio_l = 16'hFFFF; audio_r = 16'hFFFF;
    cap(512, 16'h0000, 16'h0000);
    mute = 1'b0;
    cap(512, 16'hFFFF, 16'hFFFF);

    audio_l = 16'h1234; audio_r = 16'h4321;
    cap(512, 16'h1234, 16'h4321);
    repeat (100) @(posedge clk);
    audio_l = 16'h5678;
    cap(412, 16'h5678, 16'h4321);

    repeat (300) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    audio_l = 16'hA5A5; audio_r = 16'h5A5A;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap(8, 16'hA5A5, 16'h5A5A);

    repeat (520) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Serialises the 16-bit signed stereo output of the audio mixer into an I2S (or optional left-justified) bitstream for the external DAC.
- Generates BCK and LRCK from the system clock.
- Captures one L/R sample pair per frame and pulses a strobe so upstream logic knows when a sample was consumed.
- Sits between the mixer/compressor outputs and the DAC pins.

Parameters:
- CLK_DIV, 4, clk cycles per BCK half-period; must be ≥2. BCK = clk/(2*CLK_DIV).
- SLOT_BITS, 32, BCK periods per channel slot; must be ≥ DATA_W+1. Frame = 2*SLOT_BITS BCK periods.
- DATA_W, 16, sample width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- audio_l  in  DATA_W  left sample, signed two's complement
- audio_r  in  DATA_W  right sample, signed two's complement
- mute  in  1  when high at capture, zeros are transmitted
- sample_req  out  1  one-clk pulse in the cycle the L/R pair is captured
- i2s_bck  out  1  bit clock
- i2s_lrck  out  1  word select (0 = left, 1 = right)
- i2s_data  out  1  serial data, MSB first

Behaviour:
- Reset (async, rst_n low):
  - div_cnt=0, bit_cnt=2*SLOT_BITS-1, shift register=0.
  - Outputs: i2s_bck=0, i2s_lrck=1, i2s_data=0, sample_req=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1; on wrap, i2s_bck toggles.
  - A 0→1 toggle is a rise event; a 1→0 toggle is a fall event.
  - All output changes occur only on fall events, so the DAC samples on the BCK rise.
- Bit counter: on each fall event, bit_cnt increments modulo 2*SLOT_BITS.
- Frame start (fall event where bit_cnt becomes 0):
  - Capture audio_l/audio_r, or zeros if mute is high, in that same clk cycle.
  - Load the 2*SLOT_BITS frame register as {L, zeros(SLOT_BITS-DATA_W), R, zeros(SLOT_BITS-DATA_W)}.
  - Assert sample_req for exactly that one clk cycle.
- I2S timing (default), all on fall events:
  - i2s_lrck=0 at bit_cnt=0 and 1 at bit_cnt=SLOT_BITS.
  - i2s_data presents frame bit (bit_cnt-1). The L MSB appears at bit_cnt=1 and the R MSB at bit_cnt=SLOT_BITS+1.
  - At bit_cnt=0, i2s_data shows the last R pad bit, which is 0.
- First frame after reset: the first fall event occurs 2*CLK_DIV clk cycles after rst_n deasserts, so the first sample_req is in that cycle.
- Latency: input values present in the sample_req cycle reach i2s_data with their MSB one BCK period later (I2S) or in the same cycle (LJ).
- Mid-frame behaviour:
  - Input changes between captures are ignored.
  - mute changing mid-frame has no effect until the next capture.
- Reset asserted mid-frame aborts the frame immediately. Outputs return to reset values. No partial sample_req.
- Registers: all outputs registered; no combinational path from inputs to pins.

Optional Feature:
- Macro: I2S_LJ_EN.
- Defined: left-justified format.
  - i2s_lrck is 1 for the left slot and 0 for the right slot.
  - i2s_data presents frame bit (bit_cnt), so the L MSB is driven in the capture cycle itself, taken directly from the captured input.
  - Reset value of i2s_lrck is 0.
- Undefined: standard I2S timing as described in Behaviour.
- Divider, sample_req and mute behaviour are unchanged in both modes.

Decomposition:
- Shared package audio_pkg holds:
  - AUDIO_W=16
  - default SLOT_BITS=32
  - LRCK_LEFT encoding constant
  - sample type typedef shared with the mixer
- One sub-module, i2s_bck_gen: the divider and BCK toggle, emitting the rise/fall event pulses. The top level holds the bit counter, capture logic and shifter.

Test Plan (CLK_DIV=4, SLOT_BITS=32; frame = 512 clk):
- Reset release, audio_l=16'h8001, audio_r=16'h7FFE:
  - first sample_req at clk cycle 8.
  - On BCK rises, capture L bits 1000…0001 starting one BCK after the lrck 1→0 transition, followed by 16 zeros.
  - Capture R bits 0111…1110 starting one BCK after lrck 0→1.
- Continuous run for 4 frames:
  - sample_req period is exactly 512 clk and 1 cycle wide.
  - i2s_bck period is 8 clk at 50% duty.
  - i2s_lrck period is 512 clk.
- mute=1 held across a capture with audio_l=16'hFFFF: that frame's L and R slots are all zeros. The next frame, with mute=0, carries 16'hFFFF.
- Change audio_l from 16'h1234 to 16'h5678 in mid-frame (clk 100 after capture): the current frame still sends 16'h1234, the next frame sends 16'h5678.
- Assert rst_n low at clk 300 of a frame:
  - outputs are immediately bck=0, lrck=1 (0 with I2S_LJ_EN), data=0.
  - After release, the next sample_req is 8 clk later.
- I2S_LJ_EN build, audio_l=16'hA5A5: i2s_data shows bit 15 (=1) in the capture cycle, lrck=1 for the left slot, and the 16 left bits arrive on 16 consecutive BCK rises.
